// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ctrl_pkg
//  Purpose  : Shared types and constants for the SPI master controller:
//             RAM command opcodes, controller state encoding, frame sizes
//             and a helper that builds the 11-bit SPI frame.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    localparam int FRAME_LEN = 11;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        WAIT_RD = 3'd2,
        CAPTURE = 3'd3,
        END     = 3'd4
    } spi_ctrl_state_e;

    // Bit 10 repeats op[1]; the slave uses it to select its path before
    // it has seen the full opcode.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input spi_op_e                 op,
        input logic [DATA_W-1:0]       data
    );
        return {op[1], op, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ctrl_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ctrl_shifter
//  Purpose  : Datapath for the SPI master controller.
//             - 11-bit shift-out register. Bit 10 of the frame is driven
//               directly by the controller at accept time. The register
//               therefore loads the frame pre-shifted by one, and
//               o_tx_bit always presents the next bit to drive.
//             - 8-bit MSB-first shift-in register. o_rx_next is the value
//               after the current sample, so the controller can register
//               the final byte on the same edge as the last sample.
//             - 4-bit down-counter shared by SHIFT, WAIT_RD and CAPTURE.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             i_load, i_frame load a new frame
//             i_shift         advance the shift-out register
//             i_sample        shift i_miso into the shift-in register
//             i_cnt_load/val  load the bit counter
//             i_cnt_dec       decrement the bit counter
//             o_tx_bit        next MOSI bit
//             o_rx_next       shift-in value including current i_miso
//             o_cnt           current bit counter value
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ctrl_shifter
    import spi_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [FRAME_LEN-1:0] i_frame,
    input  logic                 i_shift,
    input  logic                 i_sample,
    input  logic                 i_miso,
    input  logic                 i_cnt_load,
    input  logic [3:0]           i_cnt_val,
    input  logic                 i_cnt_dec,
    output logic                 o_tx_bit,
    output logic [DATA_W-1:0]    o_rx_next,
    output logic [3:0]           o_cnt
);

    logic [FRAME_LEN-1:0] r_tx;
    logic [DATA_W-1:0]    r_rx;
    logic [3:0]           r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx  <= '0;
            r_rx  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_load) begin
                r_tx <= {i_frame[FRAME_LEN-2:0], 1'b0};
            end else if (i_shift) begin
                r_tx <= {r_tx[FRAME_LEN-2:0], 1'b0};
            end

            if (i_sample) begin
                r_rx <= o_rx_next;
            end

            if (i_cnt_load) begin
                r_cnt <= i_cnt_val;
            end else if (i_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign o_tx_bit  = r_tx[FRAME_LEN-1];
    assign o_rx_next = {r_rx[DATA_W-2:0], i_miso};
    assign o_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_ctrl
//  Purpose  : Host-side sequencer for the SPI slave + RAM wrapper. Accepts
//             one-word RAM commands on a valid/ready port, sends each as an
//             11-bit MSB-first frame on SS_n/MOSI, and for read-data
//             captures the returned byte from MISO.
//  Macro    : SPI_CTRL_ORDER_CHECK_EN - when defined, the controller rejects
//             out-of-order write-data/read-data requests with a one-cycle
//             err pulse. When undefined, err is always 0.
//  Params   : MISO_DELAY - cycles between the last MOSI bit of a read-data
//             frame and the first MISO sample (1..15)
//  Ports    : clk, rst                    clock / sync active-high reset
//             req_valid/ready/op/data     command request handshake
//             rsp_valid, rsp_data         read-data response (1-cycle pulse)
//             err                         request rejected (1-cycle pulse)
//             busy                        controller not in IDLE
//             SS_n, MOSI, MISO            SPI pins
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int MISO_DELAY = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] c_CNT_FRAME = 4'(FRAME_LEN - 1);
    localparam logic [3:0] c_CNT_WAIT  = 4'(MISO_DELAY - 1);
    localparam logic [3:0] c_CNT_BYTE  = 4'(DATA_W - 1);

    spi_ctrl_state_e   r_state;
    spi_op_e           r_op;
    logic              r_ss_n;
    logic              r_mosi;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_err;

    logic                 w_accept;
    logic                 w_reject;
    logic                 w_start;
    logic [FRAME_LEN-1:0] w_frame;
    logic                 w_cnt_zero;
    logic                 w_shift;
    logic                 w_sample;
    logic                 w_cnt_load;
    logic [3:0]           w_cnt_val;
    logic                 w_cnt_dec;
    logic                 w_tx_bit;
    logic [DATA_W-1:0]    w_rx_next;
    logic [3:0]           w_cnt;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_frame  = build_frame(spi_op_e'(req_op), req_data);
    assign w_start  = w_accept && !w_reject;

`ifdef SPI_CTRL_ORDER_CHECK_EN
    spi_op_e r_last_op;

    always_comb begin
        w_reject = 1'b0;
        if (spi_op_e'(req_op) == WR_DATA) begin
            w_reject = (r_last_op != WR_ADDR) && (r_last_op != WR_DATA);
        end else if (spi_op_e'(req_op) == RD_DATA) begin
            w_reject = (r_last_op != RD_ADDR);
        end
    end

    // Only frames that are actually sent update the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_op <= WR_ADDR;
        end else if (w_start) begin
            r_last_op <= spi_op_e'(req_op);
        end
    end
`else
    assign w_reject = 1'b0;
`endif

    // Shifter control. The counter is reloaded on every phase change and
    // counts down to zero within each phase.
    assign w_cnt_zero = (w_cnt == 4'd0);

    always_comb begin
        w_shift    = 1'b0;
        w_sample   = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = c_CNT_FRAME;
        w_cnt_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_load = w_start;
                w_cnt_val  = c_CNT_FRAME;
            end
            SHIFT: begin
                w_shift    = !w_cnt_zero;
                w_cnt_dec  = !w_cnt_zero;
                w_cnt_load = w_cnt_zero && (r_op == RD_DATA);
                w_cnt_val  = c_CNT_WAIT;
            end
            WAIT_RD: begin
                w_cnt_dec  = !w_cnt_zero;
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = c_CNT_BYTE;
            end
            CAPTURE: begin
                w_sample  = 1'b1;
                w_cnt_dec = !w_cnt_zero;
            end
            default: begin
                w_shift = 1'b0;
            end
        endcase
    end

    spi_ctrl_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_frame    (w_frame),
        .i_shift    (w_shift),
        .i_sample   (w_sample),
        .i_miso     (MISO),
        .i_cnt_load (w_cnt_load),
        .i_cnt_val  (w_cnt_val),
        .i_cnt_dec  (w_cnt_dec),
        .o_tx_bit   (w_tx_bit),
        .o_rx_next  (w_rx_next),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= WR_ADDR;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op    <= spi_op_e'(req_op);
                            r_state <= SHIFT;
                            r_ss_n  <= 1'b0;
                            r_mosi  <= w_frame[FRAME_LEN-1];
                        end
                    end
                end
                SHIFT: begin
                    if (w_cnt_zero) begin
                        r_mosi <= 1'b0;
                        if (r_op == RD_DATA) begin
                            r_state <= WAIT_RD;
                        end else begin
                            r_state <= END;
                            r_ss_n  <= 1'b1;
                        end
                    end else begin
                        r_mosi <= w_tx_bit;
                    end
                end
                WAIT_RD: begin
                    if (w_cnt_zero) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Last sample: register the complete byte with it.
                    if (w_cnt_zero) begin
                        r_state     <= END;
                        r_ss_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rx_next;
                    end
                end
                END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_ctrl
//  Purpose  : Directed self-checking bench for spi_master_ctrl. Drives
//             command requests, plays the slave's MISO byte and compares
//             pins and responses against hand-derived values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int n_total = 0;
    int n_pass  = 0;

    spi_master_ctrl #(.MISO_DELAY(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err       (err),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request in the current (IDLE) cycle; returns in cycle 1.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    // Called in cycle 1 of a non-read-data frame; returns in cycle 13.
    task automatic check_frame(input logic [10:0] f);
        for (int c = 1; c <= 11; c++) begin
            check("ss_n_shift", SS_n, 1'b0);
            check("mosi_bit", MOSI, f[11-c]);
            check("ready_busy", req_ready, 1'b0);
            tick();
        end
        check("ss_n_end", SS_n, 1'b1);
        check("mosi_end", MOSI, 1'b0);
        check("ready_end", req_ready, 1'b0);
        tick();
        check("ready_after", req_ready, 1'b1);
        check("busy_after", busy, 1'b0);
    endtask

    // Full read-data transaction with the slave returning b.
    task automatic read_frame(input logic [7:0] b);
        logic [10:0] rf;
        int          ss_low;
        rf     = 11'b111_0000_0000;
        ss_low = 0;
        send(2'b11, 8'h00);
        for (int c = 1; c <= 19 + D; c++) begin
            if (SS_n === 1'b0) ss_low++;
            check("rd_ss_n", SS_n, 1'b0);
            check("rd_rsp_early", rsp_valid, 1'b0);
            check("rd_err", err, 1'b0);
            if (c <= 11) check("rd_mosi", MOSI, rf[11-c]);
            else         check("rd_mosi_wait", MOSI, 1'b0);
            if (c >= 12 + D) MISO = b[19+D-c];
            tick();
        end
        MISO = 1'b0;
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_data", rsp_data, b);
        check("rd_ss_n_end", SS_n, 1'b1);
        check("rd_ss_low_len", ss_low, 19 + D);
        tick();
        check("rd_rsp_pulse", rsp_valid, 1'b0);
        check("rd_rsp_hold", rsp_data, b);
        check("rd_ready", req_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 8'h00;
        MISO      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_err", err, 1'b0);

        // Write-addr 0x3C
        send(2'b00, 8'h3C);
        check_frame(11'b000_0011_1100);

        // Write-data 0x5A with a second write-data 0x77 held behind it
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 8'h5A;
        tick();
        req_data  = 8'h77;
        check_frame(11'b001_0101_1010);
        tick();
        req_valid = 1'b0;
        check_frame(11'b001_0111_0111);

        // Read-addr 0x3C then read-data returning 0xA5
        send(2'b10, 8'h3C);
        check_frame(11'b110_0011_1100);
        read_frame(8'hA5);

        // Reset in cycle 6 of a read-data frame
        send(2'b10, 8'h01);
        check_frame(11'b110_0000_0001);
        send(2'b11, 8'h00);
        repeat (5) tick();
        check("mid_ss_n_low", SS_n, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ss_n", SS_n, 1'b1);
        check("mid_mosi", MOSI, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_rsp_valid", rsp_valid, 1'b0);
        check("mid_rsp_data", rsp_data, 8'h00);
        check("mid_err", err, 1'b0);
        MISO = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            check("post_rst_rsp", rsp_valid, 1'b0);
            check("post_rst_ss_n", SS_n, 1'b1);
        end
        MISO = 1'b0;
        send(2'b00, 8'h3C);
        check_frame(11'b000_0011_1100);

        // Read-data straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`ifdef SPI_CTRL_ORDER_CHECK_EN
        send(2'b11, 8'h00);
        check("ord_err", err, 1'b1);
        check("ord_ss_n", SS_n, 1'b1);
        check("ord_busy", busy, 1'b0);
        check("ord_ready", req_ready, 1'b1);
        tick();
        check("ord_err_pulse", err, 1'b0);
        check("ord_ss_n_hold", SS_n, 1'b1);
`else
        read_frame(8'h3C);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side sequencer that drives the SPI slave + single-port RAM wrapper. It accepts one-word RAM commands on a valid/ready request port and serialises each into an SPI frame on SS_n/MOSI. For read-data commands it also deserialises the returned byte from MISO and presents it on a one-cycle response port. It sits between the system bus agent and the SPI wrapper, and is the only master of that wrapper.

## Interface

- MISO_DELAY, default 2: cycles between the last MOSI bit of a read-data frame and the first MISO sample; range 1..15.
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data
- req_data  in  8  address or write data; ignored for read-data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_data  out  8  byte read from RAM; held until next rsp_valid
- err  out  1  one-cycle pulse, request rejected (see Configuration)
- busy  out  1  high whenever state != IDLE
- SS_n  out  1  slave select, active-low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

## Operation

- Frame: 11 bits, MSB first, {req_op[1], req_op[1:0], req_data[7:0]}. Bit 10 is the slave's path-select bit.
- Accept: req_valid && req_ready. The op and data are latched, and the controller leaves IDLE.
- States:
  - IDLE: SS_n=1, MOSI=0, req_ready=1.
  - SHIFT: 11 cycles, SS_n=0, MOSI=frame[10-i].
    - Next state is WAIT_RD if op==11, else END.
  - WAIT_RD: MISO_DELAY cycles, SS_n=0, MOSI=0.
  - CAPTURE: 8 cycles, SS_n=0, MISO shifted in MSB first.
  - END: 1 cycle, SS_n=1. rsp_valid pulses here if op==11. Then IDLE.
- Requests with req_valid high outside IDLE are not accepted and are not lost. The host holds them until req_ready.
- The controller applies no ordering rules on ops unless the Configuration macro is defined.

## Timing

- Reset values, all registered: SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, err=0, busy=0, state=IDLE.
- req_ready is 1 in the first cycle after rst deasserts.
- Accept at edge N:
  - SS_n falls and MOSI=frame[10] from cycle N+1.
  - The last bit, frame[0], is driven in cycle N+11.
- Write-addr, write-data and read-addr:
  - END in cycle N+12; req_ready=1 in N+13.
  - Minimum request spacing is therefore 13 cycles.
- Read-data:
  - WAIT_RD in N+12 .. N+11+MISO_DELAY.
  - MISO sampled at the end of cycles N+12+MISO_DELAY .. N+19+MISO_DELAY, with bit 7 sampled first.
  - END, rsp_valid=1 and the new rsp_data all appear in cycle N+20+MISO_DELAY.
- rst asserted mid-frame:
  - At the next edge: SS_n=1, MOSI=0, IDLE.
  - No rsp_valid and no err. rsp_data is cleared to 0x00.
- SS_n always returns high for at least one cycle (END) between frames.

## Configuration

- SPI_CTRL_ORDER_CHECK_EN defined: the controller tracks the last accepted op (reset value 2'b00). A request is rejected if either:
  - it is write-data (01) and the last accepted op is not write-addr (00) or write-data (01), or
  - it is read-data (11) and the last accepted op is not read-addr (10).
- A rejected request:
  - is still handshaken (req_ready=1 in IDLE);
  - produces err=1 in the following cycle;
  - stays in IDLE and drives no frame;
  - does not update last-op.
- Macro undefined: no tracking. err is tied to 0 and every request produces a frame.

## Structure

- Shared package spi_ctrl_pkg holds:
  - typedef enum logic [1:0] spi_op_e {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA}
  - typedef enum spi_ctrl_state_e {IDLE, SHIFT, WAIT_RD, CAPTURE, END}
  - constants FRAME_LEN=11, DATA_W=8
- Sub-module spi_ctrl_shifter: 11-bit load/shift-out register plus 8-bit shift-in register, with a 4-bit bit counter. The top level holds the FSM, the handshake and the order checker.

## Test plan

- Reset → SS_n=1, MOSI=0, busy=0, req_ready=1 one cycle after rst falls.
- Write-addr 0x3C accepted at cycle 0 → MOSI 0,0,0,0,0,1,1,1,1,0,0 in cycles 1..11 with SS_n=0; SS_n=1 in cycle 12; req_ready=1 in cycle 13.
- Read-addr 0x3C, then read-data with the slave model returning 0xA5 (MISO_DELAY=2) → rsp_valid=1 and rsp_data=0xA5 exactly at accept+22; SS_n low for 21 cycles.
- req_valid held high through a write-data frame → second request accepted only at cycle 13; no frame overlap and SS_n high in cycle 12.
- rst pulsed at cycle 6 of a read-data frame → SS_n=1 at the next edge, no rsp_valid, rsp_data=0x00; a fresh write-addr then completes normally.
- With SPI_CTRL_ORDER_CHECK_EN: read-data right after reset → err=1 one cycle after accept, SS_n stays 1. Without the macro: the same stimulus produces a full read-data frame and err=0.
